// File: rtl/tri_wire_raster.sv
// Wireframe triangle rasterizer: walks the enabled triangle edges with a Bresenham engine and
// streams framebuffer pixel addresses. Define RASTER_CLIP_EN to suppress off-screen pixels.
module tri_wire_raster #(
   parameter int unsigned COORD_W = 8,
   parameter int unsigned FB_W    = 160,
   parameter int unsigned FB_H    = 120,
   parameter int unsigned ADDR_W  = $clog2(FB_W*FB_H)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] x1,
   input  logic [COORD_W-1:0] y1,
   input  logic [COORD_W-1:0] x2,
   input  logic [COORD_W-1:0] y2,
   input  logic [2:0]         edge_en,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [ADDR_W-1:0]  pix_addr,
   output logic               busy,
   output logic               done
);

   localparam int unsigned DW = COORD_W + 1;
   localparam int unsigned EW = COORD_W + 2;
   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

   typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;

   state_t               state, state_n;
   logic [1:0]           idx, idx_n;
   logic [2:0]           en;
   logic [COORD_W-1:0]   vx [3];
   logic [COORD_W-1:0]   vy [3];
   logic [COORD_W-1:0]   cx, cy, qx, qy;
   logic [COORD_W-1:0]   cx_n, cy_n, qx_n, qy_n;
   logic [COORD_W-1:0]   px_sel, py_sel, qx_sel, qy_sel;
   logic signed [DW-1:0] dx, dy, dx_n, dy_n;
   logic                 sx, sy, sx_n, sy_n;
   logic signed [EW-1:0] err, err_n, e2;
   logic [1:0]           nxt_idx;
   logic                 nxt_ok;
   logic                 advance;
   logic                 valid_n, busy_n, done_n;
   logic [ADDR_W-1:0]    addr_n;

   // Endpoints of the current edge and the next enabled edge after it, if any.
   always_comb begin
      px_sel = vx[2];
      py_sel = vy[2];
      qx_sel = vx[0];
      qy_sel = vy[0];
      case (idx)
         2'd0: begin
            px_sel = vx[0]; py_sel = vy[0]; qx_sel = vx[1]; qy_sel = vy[1];
         end
         2'd1: begin
            px_sel = vx[1]; py_sel = vy[1]; qx_sel = vx[2]; qy_sel = vy[2];
         end
         default: ;
      endcase
      nxt_ok  = 1'b0;
      nxt_idx = idx;
      if (idx == 2'd0 && en[1]) begin
         nxt_ok  = 1'b1;
         nxt_idx = 2'd1;
      end else if (idx != 2'd2 && en[2]) begin
         nxt_ok  = 1'b1;
         nxt_idx = 2'd2;
      end
   end

   // Next state, edge walker and registered-output inputs.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      cx_n    = cx;
      cy_n    = cy;
      qx_n    = qx;
      qy_n    = qy;
      dx_n    = dx;
      dy_n    = dy;
      sx_n    = sx;
      sy_n    = sy;
      err_n   = err;
      e2      = err <<< 1;
      advance = pix_ready || !pix_valid;

      case (state)
         IDLE: begin
            idx_n = 2'd0;
            if (start) state_n = LOAD;
         end
         LOAD: begin
            if (en[idx]) begin
               state_n = STEP;
               cx_n    = px_sel;
               cy_n    = py_sel;
               qx_n    = qx_sel;
               qy_n    = qy_sel;
               sx_n    = qx_sel < px_sel;
               sy_n    = qy_sel < py_sel;
               dx_n    = $signed(DW'(sx_n ? px_sel - qx_sel : qx_sel - px_sel));
               dy_n    = -$signed(DW'(sy_n ? py_sel - qy_sel : qy_sel - py_sel));
               err_n   = EW'(dx_n) + EW'(dy_n);
            end else if (nxt_ok) begin
               idx_n = nxt_idx;
            end else begin
               state_n = DONE;
            end
         end
         STEP: begin
            if (advance) begin
               if (cx == qx && cy == qy) begin
                  // Edge finished: fold the edge-advance into this cycle.
                  if (nxt_ok) begin
                     state_n = LOAD;
                     idx_n   = nxt_idx;
                  end else begin
                     state_n = DONE;
                  end
               end else begin
                  if (e2 >= EW'(dy)) begin
                     err_n = err_n + EW'(dy);
                     cx_n  = sx ? cx - ONE : cx + ONE;
                  end
                  if (e2 <= EW'(dx)) begin
                     err_n = err_n + EW'(dx);
                     cy_n  = sy ? cy - ONE : cy + ONE;
                  end
               end
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase

`ifdef RASTER_CLIP_EN
      valid_n = (state_n == STEP) && (32'(cx_n) < FB_W) && (32'(cy_n) < FB_H);
`else
      valid_n = (state_n == STEP);
`endif
      addr_n = ADDR_W'(32'(cy_n) * FB_W + 32'(cx_n));
      busy_n = (state_n == LOAD) || (state_n == STEP);
      done_n = (state_n == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pix_valid <= 1'b0;
         pix_addr  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         pix_valid <= valid_n;
         pix_addr  <= addr_n;
         busy      <= busy_n;
         done      <= done_n;
      end
   end

   // Latched triangle and edge-walker datapath; only meaningful while busy.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         vx[0] <= x0;
         vy[0] <= y0;
         vx[1] <= x1;
         vy[1] <= y1;
         vx[2] <= x2;
         vy[2] <= y2;
         en    <= edge_en;
      end
      idx <= idx_n;
      cx  <= cx_n;
      cy  <= cy_n;
      qx  <= qx_n;
      qy  <= qy_n;
      dx  <= dx_n;
      dy  <= dy_n;
      sx  <= sx_n;
      sy  <= sy_n;
      err <= err_n;
   end

endmodule

// File: tb/tb_tri_wire_raster.sv
// Directed self-checking bench for tri_wire_raster on a 16x16 framebuffer.
// Expected pixel streams and cycle numbers are hand-derived relative to the start cycle T.
module tb_tri_wire_raster;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] x0, y0, x1, y1, x2, y2;
   logic [2:0] edge_en;
   logic       pix_valid;
   logic       pix_ready;
   logic [7:0] pix_addr;
   logic       busy;
   logic       done;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int got_addr [$];
   int got_cyc [$];
   int stall_addr [$];
   int done_cyc;
   int busy_cnt;

   tri_wire_raster #(
      .COORD_W(8), .FB_W(16), .FB_H(16), .ADDR_W(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
      .edge_en(edge_en), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_addr(pix_addr), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a triangle during cycle T, return in cycle T+1 with inputs scrambled.
   task automatic start_tri(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int ax2, input int ay2, input logic [2:0] en);
      x0 = 8'(ax0); y0 = 8'(ay0); x1 = 8'(ax1); y1 = 8'(ay1); x2 = 8'(ax2); y2 = 8'(ay2);
      edge_en = en;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      x0 = 8'd99; y0 = 8'd77; x1 = 8'd42; y1 = 8'd11; x2 = 8'd250; y2 = 8'd3;
      edge_en = 3'b111;
   endtask

   // Record accepted pixels until done (bounded); returns in the cycle after done.
   task automatic collect(input int max_cyc, input int stall_idx, input int stall_len,
                          input bit hold_start);
      int stalled = 0;
      got_addr.delete();
      got_cyc.delete();
      stall_addr.delete();
      done_cyc = -1;
      busy_cnt = 0;
      for (int c = 1; c <= max_cyc; c++) begin
         pix_ready = 1'b1;
         if (pix_valid && int'(got_addr.size()) == stall_idx && stalled < stall_len) begin
            pix_ready = 1'b0;
            stalled++;
            stall_addr.push_back(int'(pix_addr));
         end
         if (busy) busy_cnt++;
         if (pix_valid && pix_ready) begin
            got_addr.push_back(int'(pix_addr));
            got_cyc.push_back(c);
         end
         start = hold_start && !done;
         if (done) begin
            done_cyc = c;
            tick();
            break;
         end
         tick();
      end
      pix_ready = 1'b1;
      start     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      chk_cnt++; if (pix_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", pix_valid); else pass_cnt++;
      chk_cnt++; if (pix_addr !== 8'd0) $display("FAIL reset_addr: got %0d want 0", pix_addr); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
      chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else pass_cnt++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_full_triangle();
      int exp_a [$] = '{0, 1, 2, 3, 3, 18, 33, 48, 48, 32, 16, 0};
      int exp_c [$] = '{2, 3, 4, 5, 7, 8, 9, 10, 12, 13, 14, 15};
      start_tri(0, 0, 3, 0, 0, 3, 3'b111);
      chk_cnt++; if (busy !== 1'b1) $display("FAIL full_busy_rise: got %0b want 1", busy); else pass_cnt++;
      chk_cnt++; if (pix_valid !== 1'b0) $display("FAIL full_load_valid: got %0b want 0", pix_valid); else pass_cnt++;
      collect(40, -1, 0, 1'b0);
      chk_cnt++; if (got_addr.size() != 12) $display("FAIL full_count: got %0d want 12", got_addr.size()); else pass_cnt++;
      for (int i = 0; i < 12; i++) begin
         int ga = (i < int'(got_addr.size())) ? got_addr[i] : -1;
         int gc = (i < int'(got_cyc.size())) ? got_cyc[i] : -1;
         chk_cnt++; if (ga !== exp_a[i]) $display("FAIL full_addr[%0d]: got %0d want %0d", i, ga, exp_a[i]); else pass_cnt++;
         chk_cnt++; if (gc !== exp_c[i]) $display("FAIL full_cycle[%0d]: got T+%0d want T+%0d", i, gc, exp_c[i]); else pass_cnt++;
      end
      chk_cnt++; if (done_cyc !== 16) $display("FAIL full_done_cycle: got T+%0d want T+16", done_cyc); else pass_cnt++;
      chk_cnt++; if (busy_cnt !== 15) $display("FAIL full_busy_cycles: got %0d want 15", busy_cnt); else pass_cnt++;
      chk_cnt++; if (done !== 1'b0) $display("FAIL full_done_pulse: got %0b want 0", done); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL full_idle_busy: got %0b want 0", busy); else pass_cnt++;
   endtask

   // Middle edge only, with start held high and inputs scrambled while busy.
   task automatic test_single_edge();
      int exp_a [$] = '{3, 18, 33, 48};
      int exp_c [$] = '{3, 4, 5, 6};
      start_tri(0, 0, 3, 0, 0, 3, 3'b010);
      collect(40, -1, 0, 1'b1);
      chk_cnt++; if (got_addr.size() != 4) $display("FAIL edge_count: got %0d want 4", got_addr.size()); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         int ga = (i < int'(got_addr.size())) ? got_addr[i] : -1;
         int gc = (i < int'(got_cyc.size())) ? got_cyc[i] : -1;
         chk_cnt++; if (ga !== exp_a[i]) $display("FAIL edge_addr[%0d]: got %0d want %0d", i, ga, exp_a[i]); else pass_cnt++;
         chk_cnt++; if (gc !== exp_c[i]) $display("FAIL edge_cycle[%0d]: got T+%0d want T+%0d", i, gc, exp_c[i]); else pass_cnt++;
      end
      chk_cnt++; if (done_cyc !== 7) $display("FAIL edge_done_cycle: got T+%0d want T+7", done_cyc); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL edge_idle_busy: got %0b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int exp_a [$] = '{0, 1, 2, 3, 3, 18, 33, 48, 48, 32, 16, 0};
      int bad = 0;
      start_tri(0, 0, 3, 0, 0, 3, 3'b111);
      collect(40, 1, 3, 1'b0);
      chk_cnt++; if (stall_addr.size() != 3) $display("FAIL bp_stall_cycles: got %0d want 3", stall_addr.size()); else pass_cnt++;
      foreach (stall_addr[i]) if (stall_addr[i] != 1) bad++;
      chk_cnt++; if (bad !== 0) $display("FAIL bp_held_addr: got %0d cycles not holding addr 1 want 0", bad); else pass_cnt++;
      chk_cnt++; if (got_addr.size() != 12) $display("FAIL bp_count: got %0d want 12", got_addr.size()); else pass_cnt++;
      for (int i = 0; i < 12; i++) begin
         int ga = (i < int'(got_addr.size())) ? got_addr[i] : -1;
         chk_cnt++; if (ga !== exp_a[i]) $display("FAIL bp_addr[%0d]: got %0d want %0d", i, ga, exp_a[i]); else pass_cnt++;
      end
      chk_cnt++; if (got_cyc.size() < 2 || got_cyc[1] !== 6) $display("FAIL bp_accept_cycle: got size %0d want second accept at T+6", got_cyc.size()); else pass_cnt++;
      chk_cnt++; if (done_cyc !== 19) $display("FAIL bp_done_cycle: got T+%0d want T+19", done_cyc); else pass_cnt++;
   endtask

   task automatic test_degenerate();
      int exp_c [$] = '{2, 4, 6};
      start_tri(5, 5, 5, 5, 5, 5, 3'b111);
      collect(40, -1, 0, 1'b0);
      chk_cnt++; if (got_addr.size() != 3) $display("FAIL degen_count: got %0d want 3", got_addr.size()); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         int ga = (i < int'(got_addr.size())) ? got_addr[i] : -1;
         int gc = (i < int'(got_cyc.size())) ? got_cyc[i] : -1;
         chk_cnt++; if (ga !== 85) $display("FAIL degen_addr[%0d]: got %0d want 85", i, ga); else pass_cnt++;
         chk_cnt++; if (gc !== exp_c[i]) $display("FAIL degen_cycle[%0d]: got T+%0d want T+%0d", i, gc, exp_c[i]); else pass_cnt++;
      end
      chk_cnt++; if (done_cyc !== 7) $display("FAIL degen_done_cycle: got T+%0d want T+7", done_cyc); else pass_cnt++;
   endtask

   // Start accepted in the idle cycle right after the previous done.
   task automatic test_back_to_back();
      int exp_a [$] = '{0, 1, 2, 3};
      start_tri(0, 0, 3, 0, 0, 3, 3'b001);
      collect(40, -1, 0, 1'b0);
      chk_cnt++; if (got_addr.size() != 4) $display("FAIL b2b_count: got %0d want 4", got_addr.size()); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         int ga = (i < int'(got_addr.size())) ? got_addr[i] : -1;
         chk_cnt++; if (ga !== exp_a[i]) $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, ga, exp_a[i]); else pass_cnt++;
      end
      chk_cnt++; if (done_cyc !== 6) $display("FAIL b2b_done_cycle: got T+%0d want T+6", done_cyc); else pass_cnt++;
   endtask

   task automatic test_no_edges();
      start_tri(1, 2, 3, 4, 5, 6, 3'b000);
      collect(20, -1, 0, 1'b0);
      chk_cnt++; if (got_addr.size() != 0) $display("FAIL none_count: got %0d want 0", got_addr.size()); else pass_cnt++;
      chk_cnt++; if (done_cyc !== 2) $display("FAIL none_done_cycle: got T+%0d want T+2", done_cyc); else pass_cnt++;
   endtask

   task automatic test_clip();
`ifdef RASTER_CLIP_EN
      int exp_a [$] = '{14, 15};
`else
      int exp_a [$] = '{14, 15, 16, 17};
`endif
      start_tri(14, 0, 17, 0, 0, 0, 3'b001);
      collect(20, -1, 0, 1'b0);
      chk_cnt++; if (got_addr.size() != exp_a.size()) $display("FAIL clip_count: got %0d want %0d", got_addr.size(), exp_a.size()); else pass_cnt++;
      foreach (exp_a[i]) begin
         int ga = (i < int'(got_addr.size())) ? got_addr[i] : -1;
         chk_cnt++; if (ga !== exp_a[i]) $display("FAIL clip_addr[%0d]: got %0d want %0d", i, ga, exp_a[i]); else pass_cnt++;
      end
      chk_cnt++; if (done_cyc !== 6) $display("FAIL clip_done_cycle: got T+%0d want T+6", done_cyc); else pass_cnt++;
   endtask

   task automatic test_reset_mid_edge();
      start_tri(0, 0, 3, 0, 0, 3, 3'b111);
      pix_ready = 1'b0;
      tick();
      chk_cnt++; if (pix_valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %0b want 1", pix_valid); else pass_cnt++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pix_ready = 1'b1;
      chk_cnt++; if (pix_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", pix_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %0b want 0", busy); else pass_cnt++;
      chk_cnt++; if (done !== 1'b0) $display("FAIL rstmid_done: got %0b want 0", done); else pass_cnt++;
      chk_cnt++; if (pix_addr !== 8'd0) $display("FAIL rstmid_addr: got %0d want 0", pix_addr); else pass_cnt++;
      tick();
      chk_cnt++; if (done !== 1'b0) $display("FAIL rstmid_no_done: got %0b want 0", done); else pass_cnt++;
      start_tri(0, 0, 3, 0, 0, 3, 3'b111);
      collect(40, -1, 0, 1'b0);
      chk_cnt++; if (got_addr.size() != 12) $display("FAIL rstmid_redraw_count: got %0d want 12", got_addr.size()); else pass_cnt++;
      chk_cnt++; if (got_addr.size() == 0 || got_addr[0] !== 0) $display("FAIL rstmid_redraw_first: got size %0d want first addr 0", got_addr.size()); else pass_cnt++;
      chk_cnt++; if (done_cyc !== 16) $display("FAIL rstmid_redraw_done: got T+%0d want T+16", done_cyc); else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pix_ready = 1'b1; edge_en = 3'b000;
      x0 = 8'd0; y0 = 8'd0; x1 = 8'd0; y1 = 8'd0; x2 = 8'd0; y2 = 8'd0;
      test_reset();
      test_full_triangle();
      test_single_edge();
      test_backpressure();
      test_degenerate();
      test_back_to_back();
      test_no_edges();
      test_clip();
      test_reset_mid_edge();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
